// File: rtl/case9_sig_harness.sv
// Stimulus/response harness around the combinational case9 netlist: walks all
// 1024 input vectors and folds the five responses into a MISR plus a y1 hit count.
module case9_sig_harness #(
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = 16'h1021
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic              h,
  output logic              i,
  output logic              j,
  input  logic              y1,
  input  logic              y2,
  input  logic              y3,
  input  logic              y4,
  input  logic              y5,
  output logic              busy,
  output logic              done,
  output logic [9:0]        vec_idx,
  output logic [MISR_W-1:0] signature,
  output logic [10:0]       y1_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        vec_q, vec_d;
  logic [MISR_W-1:0] sig_q, sig_d;
  logic [10:0]       cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // One MISR step: shift with polynomial feedback, then XOR in the responses.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                 input logic [4:0]        yv);
    logic [MISR_W-1:0] nxt;
    nxt = {s[MISR_W-2:0], 1'b0};
    if (s[MISR_W-1]) nxt = nxt ^ POLY;
    nxt[4:0] = nxt[4:0] ^ yv;
    return nxt;
  endfunction

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          sig_d   = '0;
          cnt_d   = '0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (!hold) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!hold) begin
          sig_d = misr_step(sig_q, {y5, y4, y3, y2, y1});
          cnt_d = cnt_q + {10'd0, y1};
          if (vec_q == 10'd1023) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + 10'd1;
            state_d = S_APPLY;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered from the next state so they change with it.
    busy_d = (state_d == S_APPLY) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {a, b, c, d, e, f, g, h, i, j} = vec_q;
  assign vec_idx   = vec_q;
  assign signature = sig_q;
  assign y1_cnt    = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_case9_sig_harness.sv
// Scoreboard bench for case9_sig_harness with a stand-in case9 response model,
// directed hold/restart/reset scenarios and randomized hold and response masks.
module tb_case9_sig_harness;

  localparam logic [15:0] POLY_TB = 16'h1021;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic        a, b, c, d, e, f, g, h, i, j;
  logic        y1, y2, y3, y4, y5;
  logic        busy, done;
  logic [9:0]  vec_idx;
  logic [15:0] signature;
  logic [10:0] y1_cnt;

  logic [4:0]  resp_mask = 5'd0;
  logic        resp_zero = 1'b0;
  logic [9:0]  vec_pins;
  logic [4:0]  y_bus;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  typedef struct {
    logic [15:0] sig;
    int          cnt;
    int          done_edge;
  } exp_t;
  exp_t sb_q[$];

  logic [15:0] last_sig;
  int          last_cnt;

  case9_sig_harness #(.MISR_W(16), .POLY(POLY_TB)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i), .j(j),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
    .busy(busy), .done(done), .vec_idx(vec_idx),
    .signature(signature), .y1_cnt(y1_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Stand-in case9 netlist; y1 is a permutation threshold giving exactly 56 hits.
  function automatic logic [4:0] case9_fn(input logic [9:0] v);
    logic [4:0] r;
    int t;
    t    = (int'(v) * 37) % 1024;
    r[0] = (t < 56);
    r[1] = ^v;
    r[2] = (v[9:5] > v[4:0]);
    r[3] = (v[3] & ~v[7]) | v[0];
    r[4] = ((int'(v) % 7) == 3);
    return r;
  endfunction

  function automatic logic [4:0] resp_fn(input logic [9:0] v);
    if (resp_zero) return 5'd0;
    return case9_fn(v) ^ resp_mask;
  endfunction

  assign vec_pins = {a, b, c, d, e, f, g, h, i, j};
  assign y_bus    = resp_fn(vec_pins);
  assign {y5, y4, y3, y2, y1} = y_bus;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string nm);
    chk(nm, {a, b, c, d, e, f, g, h, i, j, busy, done, vec_idx, signature, y1_cnt}, 64'd0);
  endtask

  // Reference: signature as repeated multiply-by-x over GF(2) plus the response word.
  task automatic build_exp(output logic [15:0] s, output int cnt);
    logic [4:0] yv;
    logic       fb;
    s   = 16'd0;
    cnt = 0;
    for (int v = 0; v < 1024; v++) begin
      yv  = resp_fn(10'(v));
      cnt = cnt + int'(yv[0]);
      fb  = s[15];
      s   = s << 1;
      if (fb) s = s ^ POLY_TB;
      s = s ^ {11'd0, yv};
    end
  endtask

  // Monitor: every done rising edge pops one expected run result.
  initial begin
    logic done_prev;
    exp_t ex;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) chk("vec_on_pins", vec_pins, vec_idx);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
        end else begin
          ex = sb_q.pop_front();
          chk("done_latency", edge_n, ex.done_edge);
          chk("signature", signature, ex.sig);
          chk("y1_cnt", y1_cnt, ex.cnt);
          chk("final_vec_idx", vec_idx, 1023);
        end
      end
      done_prev = done;
    end
  end

  // hold_mode: 0 none, 1 directed (APPLY v100 x7, CAPTURE v500 x3), 2 random.
  task automatic run(input int hold_mode, input int ign_off, input int rst_off, input bit chk_v5);
    bit   plan [0:2047];
    int   nh, T, lim;
    exp_t ex;
    nh = 0;
    for (int k = 0; k < 2048; k++) begin
      plan[k] = 1'b0;
      if (hold_mode == 1 && ((k >= 201 && k <= 207) || (k >= 1009 && k <= 1011))) plan[k] = 1'b1;
      if (hold_mode == 2 && k >= 1 && k <= 2000) plan[k] = ($urandom_range(0, 39) == 0);
      if (plan[k]) nh++;
    end
    start = 1'b1;
    T = edge_n + 1;
    if (rst_off < 0) begin
      build_exp(ex.sig, ex.cnt);
      ex.done_edge = T + 2048 + nh;
      last_sig = ex.sig;
      last_cnt = ex.cnt;
      sb_q.push_back(ex);
    end
    @(negedge clk);
    start = 1'b0;
    chk("start_clears", {busy, done, vec_idx, signature, y1_cnt}, {1'b1, 1'b0, 37'd0});
    lim = 2048 + nh + 20;
    for (int k = 1; k < lim; k++) begin
      hold  = (k < 2048) ? plan[k] : 1'b0;
      start = (k == ign_off);
      rst   = (k == rst_off);
      if (chk_v5 && edge_n == T + 10) chk("vec5_at_T11", {vec_idx, vec_pins}, {10'd5, 10'd5});
      @(negedge clk);
      if (k == rst_off) begin
        rst = 1'b0;
        check_zero("midrun_reset");
        break;
      end
      if (rst_off < 0 && sb_q.size() == 0) break;
    end
    hold  = 1'b0;
    start = 1'b0;
    rst   = 1'b0;
    if (rst_off < 0 && sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=%0d expected completion by edge %0d", done, T + 2048 + nh);
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_values");
    rst = 1'b0;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    hold = 1'b0;
    check_zero("hold_in_idle");

    run(0, -1, -1, 1'b1);
    chk("y1_cnt_is_56", y1_cnt, 56);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    chk("hold_in_done", {done, busy, vec_idx, signature, 32'(y1_cnt)},
        {1'b1, 1'b0, 10'd1023, last_sig, 32'(last_cnt)});

    run(1, 605, -1, 1'b0);
    run(0, -1, 1401, 1'b0);
    run(0, -1, -1, 1'b0);
    chk("restart_cnt_56", y1_cnt, 56);

    resp_zero = 1'b1;
    run(0, -1, -1, 1'b0);
    chk("forced_zero", {signature, y1_cnt}, 27'd0);
    resp_zero = 1'b0;

    for (int n = 0; n < 2; n++) begin
      resp_mask = 5'($urandom);
      run(2, int'($urandom_range(3, 1900)), -1, 1'b0);
    end

    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_zero("rst_beats_start");
    @(negedge clk);
    check_zero("stays_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
